// File: rtl/queue.sv
// Byte FIFO between a four-phase deserializer handshake and a pop port; optional QUEUE_OVERWRITE_EN.
// Latency: ack_out, len_out and popped data_out/data_valid_out all appear one clock after the accepting edge.
// Backpressure: when full, ack_out is withheld until space frees (QUEUE_OVERWRITE_EN: oldest entry is overwritten instead).
module queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock_10KHZ,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     data_ready,
    output logic                     ack_out,
    input  logic                     dequeue_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid_out,
    output logic [$clog2(DEPTH):0]   len_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEN = LW'(DEPTH);

    typedef enum logic {E_IDLE, E_ACK} enq_state_t;

    enq_state_t       state, state_nxt;
    logic             ack_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    len_nxt;
    logic             full, empty, wr_en, pop, rd_adv;

    // full/empty come from the registered length only; no same-cycle look-ahead
    always_comb begin
        full  = (len_out == FULL_LEN);
        empty = (len_out == '0);
        pop   = dequeue_in && !empty;
`ifdef QUEUE_OVERWRITE_EN
        wr_en = (state == E_IDLE) && data_ready;
`else
        wr_en = (state == E_IDLE) && data_ready && !full;
`endif
        // a write into a full buffer drops the oldest entry unless a pop already removed it
        rd_adv  = pop || (wr_en && full);
        len_nxt = len_out;
        if (wr_en && !full && !pop)
            len_nxt = len_out + 1'b1;
        else if (pop && !wr_en)
            len_nxt = len_out - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        case (state)
            E_IDLE: begin
                if (wr_en) begin
                    state_nxt = E_ACK;
                    ack_nxt   = 1'b1;
                end
            end
            E_ACK: begin
                if (data_ready)
                    ack_nxt = 1'b1;
                else
                    state_nxt = E_IDLE;
            end
            default: state_nxt = E_IDLE;
        endcase
    end

    always_ff @(posedge clock_10KHZ) begin
        if (!reset) begin
            state          <= E_IDLE;
            ack_out        <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            len_out        <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            state          <= state_nxt;
            ack_out        <= ack_nxt;
            len_out        <= len_nxt;
            data_valid_out <= pop;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv)
                rd_ptr <= rd_ptr + 1'b1;
            if (pop)
                data_out <= mem[rd_ptr];
        end
    end

    // storage is not cleared by reset; the pointers make old contents unreachable
    always_ff @(posedge clock_10KHZ) begin
        if (reset && wr_en)
            mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_queue.sv
`timescale 1ns/1ps
module tb_queue;

    logic       clock_10KHZ = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_ready;
    logic       ack_out;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic [3:0] len_out;

    int errors = 0;
    int checks = 0;

    queue #(.DEPTH(8), .WIDTH(8)) dut (
        .clock_10KHZ    (clock_10KHZ),
        .reset          (reset),
        .data_in        (data_in),
        .data_ready     (data_ready),
        .ack_out        (ack_out),
        .dequeue_in     (dequeue_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .len_out        (len_out)
    );

    always #50 clock_10KHZ = ~clock_10KHZ;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_10KHZ);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        data_in    = b;
        data_ready = 1'b1;
        tick();
        while (!ack_out && n < 20) begin
            tick();
            n++;
        end
        check("push_ack", 32'(ack_out), 32'd1);
        data_ready = 1'b0;
        tick();
        check("push_release", 32'(ack_out), 32'd0);
    endtask

    task automatic pop_exp(input logic [7:0] b);
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        check("pop_vld", 32'(data_valid_out), 32'd1);
        check("pop_dat", 32'(data_out), 32'(b));
    endtask

    initial begin
        reset      = 1'b0;
        data_in    = 8'h00;
        data_ready = 1'b0;
        dequeue_in = 1'b0;
        tick();
        tick();
        check("rst_ack", 32'(ack_out), 32'd0);
        check("rst_len", 32'(len_out), 32'd0);
        check("rst_vld", 32'(data_valid_out), 32'd0);
        check("rst_dat", 32'(data_out), 32'd0);
        reset = 1'b1;

        // single handshake, byte written once while ack is held
        data_in    = 8'hA5;
        data_ready = 1'b1;
        tick();
        check("hs_ack", 32'(ack_out), 32'd1);
        check("hs_len", 32'(len_out), 32'd1);
        tick();
        check("hs_hold_ack", 32'(ack_out), 32'd1);
        check("hs_hold_len", 32'(len_out), 32'd1);
        data_ready = 1'b0;
        tick();
        check("hs_drop_ack", 32'(ack_out), 32'd0);
        pop_exp(8'hA5);
        check("hs_len0", 32'(len_out), 32'd0);
        tick();
        check("vld_pulse", 32'(data_valid_out), 32'd0);
        check("dat_hold", 32'(data_out), 32'hA5);

        // fill then drain back-to-back
        for (int i = 1; i <= 8; i++) push(8'(i));
        check("fill_len", 32'(len_out), 32'd8);
        dequeue_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("drain_vld", 32'(data_valid_out), 32'd1);
            check("drain_dat", 32'(data_out), 32'(i));
        end
        dequeue_in = 1'b0;
        check("drain_len", 32'(len_out), 32'd0);
        tick();
        check("drain_vld_end", 32'(data_valid_out), 32'd0);

        // full condition
        for (int i = 1; i <= 8; i++) push(8'(i));
        data_in    = 8'hFF;
        data_ready = 1'b1;
        tick();
`ifdef QUEUE_OVERWRITE_EN
        check("ovr_ack", 32'(ack_out), 32'd1);
        check("ovr_len", 32'(len_out), 32'd8);
        data_ready = 1'b0;
        tick();
`else
        check("full_ack", 32'(ack_out), 32'd0);
        check("full_len", 32'(len_out), 32'd8);
        tick();
        check("full_ack2", 32'(ack_out), 32'd0);
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        check("full_pop_dat", 32'(data_out), 32'h01);
        check("full_pop_len", 32'(len_out), 32'd7);
        check("full_pop_ack", 32'(ack_out), 32'd0);
        tick();
        check("full_late_ack", 32'(ack_out), 32'd1);
        check("full_late_len", 32'(len_out), 32'd8);
        data_ready = 1'b0;
        tick();
`endif
        for (int i = 2; i <= 8; i++) pop_exp(8'(i));
        pop_exp(8'hFF);
        check("full_end_len", 32'(len_out), 32'd0);

        // pop on empty, then write+pop on empty
        dequeue_in = 1'b1;
        tick();
        check("empty_pop_vld", 32'(data_valid_out), 32'd0);
        check("empty_pop_dat", 32'(data_out), 32'hFF);
        check("empty_pop_len", 32'(len_out), 32'd0);
        data_in    = 8'h3C;
        data_ready = 1'b1;
        tick();
        check("nobypass_len", 32'(len_out), 32'd1);
        check("nobypass_vld", 32'(data_valid_out), 32'd0);
        data_ready = 1'b0;
        tick();
        dequeue_in = 1'b0;
        check("nobypass_pop_vld", 32'(data_valid_out), 32'd1);
        check("nobypass_pop_dat", 32'(data_out), 32'h3C);
        check("nobypass_pop_len", 32'(len_out), 32'd0);

        // simultaneous write and pop on non-empty
        push(8'h11);
        data_in    = 8'h22;
        data_ready = 1'b1;
        dequeue_in = 1'b1;
        tick();
        check("sim_len", 32'(len_out), 32'd1);
        check("sim_dat", 32'(data_out), 32'h11);
        check("sim_ack", 32'(ack_out), 32'd1);
        data_ready = 1'b0;
        dequeue_in = 1'b0;
        tick();
        pop_exp(8'h22);

        // 20 bytes streamed with occupancy 4..5, wrapping pointers
        for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
        for (int i = 0; i < 16; i++) begin
            push(8'h54 + 8'(i));
            check("wrap_len_hi", 32'(len_out), 32'd5);
            pop_exp(8'h50 + 8'(i));
            check("wrap_len_lo", 32'(len_out), 32'd4);
        end
        for (int i = 16; i < 20; i++) pop_exp(8'h50 + 8'(i));
        check("wrap_end_len", 32'(len_out), 32'd0);

        // reset mid-handshake overrides everything
        for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
        data_in    = 8'h77;
        data_ready = 1'b1;
        tick();
        check("pre_rst_ack", 32'(ack_out), 32'd1);
        check("pre_rst_len", 32'(len_out), 32'd4);
        reset      = 1'b0;
        dequeue_in = 1'b1;
        tick();
        check("mid_rst_ack", 32'(ack_out), 32'd0);
        check("mid_rst_len", 32'(len_out), 32'd0);
        check("mid_rst_vld", 32'(data_valid_out), 32'd0);
        check("mid_rst_dat", 32'(data_out), 32'd0);
        reset      = 1'b1;
        data_ready = 1'b0;
        dequeue_in = 1'b0;
        tick();
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        check("post_rst_vld", 32'(data_valid_out), 32'd0);
        check("post_rst_len", 32'(len_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
